// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: fetches sequential words from the MMU into a
// circular buffer and presents the head entry to the control path.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] fetch_addr,
    input  logic [31:0] mem_instr,
    input  logic        wait_instr,
    input  logic        instr_segv,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        instr_fault,
    input  logic        pc_inc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic {
        RUN,
        FAULTED
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic [31:0] q_instr [DEPTH];
    logic [31:0] q_pc    [DEPTH];
    logic        q_fault [DEPTH];

    logic fetching;
    logic accept;
    logic pop;
    logic nonempty;

    assign nonempty = (count != '0);
    assign pop      = pc_inc && nonempty && !redirect;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A fault marker parks the fetcher until the control path redirects.
    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = RUN;
        end else if (accept && instr_segv) begin
            state_nxt = FAULTED;
        end
    end

    always_comb begin
        fetching = (state == RUN) && !redirect;
        accept   = fetching && !wait_instr && ((count != FULL) || pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= RESET_PC;
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= {redirect_pc[31:2], 2'b00};
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!instr_segv) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is gated by count.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_fault[wr_ptr] <= instr_segv;
            q_pc[wr_ptr]    <= fetch_addr;
            q_instr[wr_ptr] <= instr_segv ? 32'h0 : mem_instr;
        end
    end

    assign instr_valid = nonempty;
    assign instruction = nonempty ? q_instr[rd_ptr] : 32'h0;
    assign instr_pc    = nonempty ? q_pc[rd_ptr] : 32'h0;
    assign instr_fault = nonempty ? q_fault[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: inputs driven and outputs
// sampled on the falling edge, away from the active rising edge.
module tb_instr_fetch_queue;

    logic        clk;
    logic        reset_n;
    logic [31:0] fetch_addr;
    logic [31:0] mem_instr;
    logic        wait_instr;
    logic        instr_segv;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_fault;
    logic        pc_inc;
    logic        redirect;
    logic [31:0] redirect_pc;

    int tests;
    int fails;

    instr_fetch_queue dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch_addr  (fetch_addr),
        .mem_instr   (mem_instr),
        .wait_instr  (wait_instr),
        .instr_segv  (instr_segv),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_fault (instr_fault),
        .pc_inc      (pc_inc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: each word holds its own address plus one.
    assign mem_instr = fetch_addr + 32'd1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n     = 1'b0;
        wait_instr  = 1'b0;
        instr_segv  = 1'b0;
        pc_inc      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        step(2);
        tests++;
        if ({instr_valid, instr_fault, instr_pc, instruction, fetch_addr}
            !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_state: v=%b f=%b pc=%h ins=%h fa=%h",
                     instr_valid, instr_fault, instr_pc, instruction,
                     fetch_addr);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_fill;
        step(1);
        tests++;
        if ({instr_valid, instr_pc, instruction, fetch_addr}
            !== {1'b1, 32'h0, 32'h1, 32'h4}) begin
            fails++;
            $display("FAIL first_latency: v=%b pc=%h ins=%h fa=%h exp 1/0/1/4",
                     instr_valid, instr_pc, instruction, fetch_addr);
        end
        step(3);
        tests++;
        if ({instr_valid, instr_pc, fetch_addr} !== {1'b1, 32'h0, 32'h10}) begin
            fails++;
            $display("FAIL fill_four: v=%b pc=%h fa=%h exp 1/0/10",
                     instr_valid, instr_pc, fetch_addr);
        end
        step(2);
        tests++;
        if (fetch_addr !== 32'h10) begin
            fails++;
            $display("FAIL full_hold: fa=%h exp 10", fetch_addr);
        end
    endtask

    task automatic test_back_to_back;
        pc_inc = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            tests++;
            if ({instr_valid, instr_pc, instruction, fetch_addr}
                !== {1'b1, 32'(4 * k), 32'(4 * k + 1), 32'(32'h10 + 4 * k)})
            begin
                fails++;
                $display("FAIL stream_%0d: v=%b pc=%h ins=%h fa=%h",
                         k, instr_valid, instr_pc, instruction, fetch_addr);
            end
        end
        pc_inc = 1'b0;
        step(2);
        tests++;
        if ({instr_pc, fetch_addr} !== {32'h10, 32'h20}) begin
            fails++;
            $display("FAIL stream_full: pc=%h fa=%h exp 10/20",
                     instr_pc, fetch_addr);
        end
    endtask

    task automatic test_wait;
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(2);
        wait_instr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            tests++;
            if ({fetch_addr, instr_pc} !== {32'h8, 32'h0}) begin
                fails++;
                $display("FAIL wait_hold_%0d: fa=%h pc=%h exp 8/0",
                         k, fetch_addr, instr_pc);
            end
        end
        wait_instr = 1'b0;
        step(1);
        tests++;
        if (fetch_addr !== 32'hC) begin
            fails++;
            $display("FAIL wait_release: fa=%h exp c", fetch_addr);
        end
        wait_instr = 1'b1;
        pc_inc     = 1'b1;
        step(1);
        tests++;
        if (instr_pc !== 32'h4) begin
            fails++;
            $display("FAIL drain_1: pc=%h exp 4", instr_pc);
        end
        step(1);
        tests++;
        if ({instr_pc, instruction} !== {32'h8, 32'h9}) begin
            fails++;
            $display("FAIL drain_2: pc=%h ins=%h exp 8/9", instr_pc, instruction);
        end
        step(1);
        tests++;
        if ({instr_valid, instr_pc, instruction} !== {1'b0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL drain_empty: v=%b pc=%h ins=%h",
                     instr_valid, instr_pc, instruction);
        end
        step(1);
        tests++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL pop_empty: v=%b exp 0", instr_valid);
        end
        pc_inc     = 1'b0;
        wait_instr = 1'b0;
        step(1);
        tests++;
        if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'hC, 32'hD}) begin
            fails++;
            $display("FAIL refill: v=%b pc=%h ins=%h exp 1/c/d",
                     instr_valid, instr_pc, instruction);
        end
    endtask

    task automatic test_fault;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step(1);
        redirect   = 1'b0;
        instr_segv = 1'b1;
        step(1);
        tests++;
        if ({instr_valid, instr_fault, instr_pc, instruction, fetch_addr}
            !== {1'b1, 1'b1, 32'h40, 32'h0, 32'h40}) begin
            fails++;
            $display("FAIL fault_head: v=%b f=%b pc=%h ins=%h fa=%h",
                     instr_valid, instr_fault, instr_pc, instruction,
                     fetch_addr);
        end
        instr_segv = 1'b0;
        pc_inc     = 1'b1;
        step(1);
        pc_inc = 1'b0;
        step(3);
        tests++;
        if ({instr_valid, fetch_addr} !== {1'b0, 32'h40}) begin
            fails++;
            $display("FAIL faulted_idle: v=%b fa=%h exp 0/40",
                     instr_valid, fetch_addr);
        end
    endtask

    task automatic test_redirect;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step(1);
        redirect = 1'b0;
        step(3);
        tests++;
        if ({instr_pc, fetch_addr} !== {32'h100, 32'h10C}) begin
            fails++;
            $display("FAIL redirect_prefill: pc=%h fa=%h exp 100/10c",
                     instr_pc, fetch_addr);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h1003;
        pc_inc      = 1'b1;
        step(1);
        redirect = 1'b0;
        pc_inc   = 1'b0;
        tests++;
        if ({instr_valid, instr_pc, instruction, fetch_addr}
            !== {1'b0, 32'h0, 32'h0, 32'h1000}) begin
            fails++;
            $display("FAIL redirect_flush: v=%b pc=%h ins=%h fa=%h",
                     instr_valid, instr_pc, instruction, fetch_addr);
        end
        step(1);
        tests++;
        if ({instr_valid, instr_pc, instruction, fetch_addr}
            !== {1'b1, 32'h1000, 32'h1001, 32'h1004}) begin
            fails++;
            $display("FAIL redirect_push: v=%b pc=%h ins=%h fa=%h",
                     instr_valid, instr_pc, instruction, fetch_addr);
        end
    endtask

    task automatic test_async_reset;
        step(1);
        wait_instr = 1'b1;
        tests++;
        if (instr_pc !== 32'h1000 || fetch_addr !== 32'h1008) begin
            fails++;
            $display("FAIL two_queued: pc=%h fa=%h exp 1000/1008",
                     instr_pc, fetch_addr);
        end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if ({instr_valid, instr_fault, instr_pc, instruction, fetch_addr}
            !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL async_reset: v=%b f=%b pc=%h ins=%h fa=%h",
                     instr_valid, instr_fault, instr_pc, instruction,
                     fetch_addr);
        end
        #1 reset_n = 1'b1;
        wait_instr = 1'b0;
        step(1);
        tests++;
        if ({instr_valid, instr_pc, instruction, fetch_addr}
            !== {1'b1, 32'h0, 32'h1, 32'h4}) begin
            fails++;
            $display("FAIL reset_resume: v=%b pc=%h ins=%h fa=%h",
                     instr_valid, instr_pc, instruction, fetch_addr);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_wait();
        test_fault();
        test_redirect();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 fetch_addr  output  32  word address driven to the MMU instruction port.
REQ-006 mem_instr  input  32  instruction word returned by the MMU for fetch_addr.
REQ-007 wait_instr  input  1  MMU not ready; mem_instr/instr_segv invalid this cycle.
REQ-008 instr_segv  input  1  MMU fault for fetch_addr, valid when wait_instr=0.
REQ-009 instruction  output  32  head-of-queue instruction to the control path.
REQ-010 instr_pc  output  32  address the head instruction was fetched from.
REQ-011 instr_valid  output  1  head entry present.
REQ-012 instr_fault  output  1  head entry is a fault marker (instruction=0).
REQ-013 pc_inc  input  1  control path consumes the head entry.
REQ-014 redirect  input  1  flush queue and restart fetch at redirect_pc.
REQ-015 redirect_pc  input  32  new fetch target; bits [1:0] are ignored (forced to 0).

Function
REQ-016 Each entry SHALL hold {fault, pc[31:0], instr[31:0]}; circular buffer with read pointer, write pointer and count (0..DEPTH).
REQ-017 State machine SHALL have two states: RUN (fetching) and FAULTED (fetch stopped).
REQ-018 Accept condition: state RUN, redirect=0, wait_instr=0, and (count<DEPTH or pop this cycle).
REQ-019 On accept with instr_segv=0: push {0, fetch_addr, mem_instr}; fetch_addr += 4 (mod 2^32).
REQ-020 On accept with instr_segv=1: push {1, fetch_addr, 0}; fetch_addr unchanged; state -> FAULTED.
REQ-021 In FAULTED no further pushes SHALL occur regardless of MMU inputs; only redirect or reset leaves FAULTED.
REQ-022 Pop condition: pc_inc=1, count>0, redirect=0; read pointer advances, count decrements.
REQ-023 pc_inc with count=0 SHALL be ignored (no pointer or count change).
REQ-024 Simultaneous push and pop SHALL keep count unchanged, including at count=DEPTH.
REQ-025 Redirect has highest priority: count<=0, pointers<=0, fetch_addr<={redirect_pc[31:2],2'b00}, state<=RUN; no push or pop that cycle.
REQ-026 First fetch at the redirect target SHALL be accepted no earlier than the cycle after redirect (1-cycle redirect bubble).
REQ-027 instruction, instr_pc, instr_fault SHALL reflect the head entry combinationally from storage; all zero when count=0.
REQ-028 instr_valid SHALL equal (count!=0).
REQ-029 Best-case latency: word accepted in cycle N is visible at the head in cycle N+1 when the queue was empty.
REQ-030 Sustained throughput SHALL be one instruction per cycle when wait_instr=0 and pc_inc=1 every cycle.
REQ-031 fetch_addr SHALL be held stable while wait_instr=1 or the queue is full without pop.

Reset
REQ-032 On reset_n=0, asynchronously: count=0, pointers=0, fetch_addr=RESET_PC, state=RUN, instr_valid=0, instruction=0, instr_pc=0, instr_fault=0.
REQ-033 Reset asserted mid-fetch or mid-wait SHALL discard all entries; no entry survives reset.
REQ-034 First accept after reset SHALL occur no earlier than the first rising edge with reset_n=1.

Verification
REQ-035 Reset release, wait_instr=0, mem_instr=addr+1, pc_inc=0 -> four pushes at 0,4,8,C, then fetch_addr holds 0x10, instr_valid=1, instr_pc=0.
REQ-036 Queue full, pc_inc=1 held, wait_instr=0 -> one push and one pop per cycle, count stays 4, instr_pc increments by 4 each cycle.
REQ-037 wait_instr=1 for 3 cycles at fetch_addr 0x8 -> no push, fetch_addr=0x8 throughout, push at 0x8 on the first wait_instr=0 cycle.
REQ-038 instr_segv=1 at fetch_addr 0x40 -> fault entry with instr_pc=0x40, instruction=0, instr_fault=1 at head; no further pushes while FAULTED.
REQ-039 redirect=1, redirect_pc=0x1003 with 3 entries and pc_inc=1 same cycle -> next cycle instr_valid=0, fetch_addr=0x1000, state RUN; next push tagged 0x1000.
REQ-040 reset_n pulsed low between edges with 2 entries queued -> outputs zero immediately, fetch_addr=RESET_PC, fetching resumes after release.
